hilo_muldiv: RTL and testbench



---
 rtl/muldiv_pkg.sv | 28 ++
 rtl/muldiv_step.sv | 79 +++++++
 rtl/hilo_muldiv.sv | 161 ++++++++++++++++
 tb/tb_hilo_muldiv.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the Hi/Lo multiply/divide unit.
package muldiv_pkg;

  localparam int DATA_W = 32;
  localparam int ITER   = 32;
  localparam int CNT_W  = 6;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_e;

  // Absolute value of a two's complement word; -2^31 maps to 0x8000_0000,
  // which is the correct unsigned magnitude.
  function automatic logic [DATA_W-1:0] magnitude(input logic [DATA_W-1:0] v);
    return v[DATA_W-1] ? (~v + DATA_W'(1)) : v;
  endfunction

  // Two's complement negation.
  function automatic logic [DATA_W-1:0] negate(input logic [DATA_W-1:0] v);
    return ~v + DATA_W'(1);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration of either a radix-2 Booth multiply step or a
// restoring divide step. Both share a single 33-bit add/subtract adder.
module muldiv_step
  import muldiv_pkg::*;
(
  input  logic              op,
  input  logic [DATA_W:0]   acc_in,
  input  logic [DATA_W-1:0] q_in,
  input  logic              q_m1_in,
  input  logic [DATA_W:0]   m_in,
  output logic [DATA_W:0]   acc_out,
  output logic [DATA_W-1:0] q_out,
  output logic              q_m1_out
);

  logic [DATA_W:0] add_a;
  logic [DATA_W:0] add_b;
  logic [DATA_W:0] sum;
  logic            add_en;
  logic            sub_en;

  // Pick adder operands: divide shifts {R,Q} left and always subtracts the
  // divisor; multiply adds/subtracts M according to the Booth pair.
  always_comb begin
    add_a  = acc_in;
    add_en = 1'b0;
    sub_en = 1'b0;
    if (op == OP_DIV) begin
      add_a  = {acc_in[DATA_W-1:0], q_in[DATA_W-1]};
      add_en = 1'b1;
      sub_en = 1'b1;
    end else begin
      case ({q_in[0], q_m1_in})
        2'b01: begin
          add_en = 1'b1;
        end
        2'b10: begin
          add_en = 1'b1;
          sub_en = 1'b1;
        end
        default: begin
          add_en = 1'b0;
        end
      endcase
    end
  end

  // The single shared adder; subtraction is invert-and-carry-in.
  always_comb begin
    add_b = '0;
    if (add_en) begin
      add_b = sub_en ? ~m_in : m_in;
    end
    sum = add_a + add_b + (DATA_W + 1)'(sub_en);
  end

  // Form the next accumulator state: restore-or-keep for divide, arithmetic
  // shift right of the whole 65-bit product register for multiply.
  always_comb begin
    acc_out  = acc_in;
    q_out    = q_in;
    q_m1_out = q_m1_in;
    if (op == OP_DIV) begin
      q_m1_out = 1'b0;
      if (!sum[DATA_W]) begin
        acc_out = sum;
        q_out   = {q_in[DATA_W-2:0], 1'b1};
      end else begin
        acc_out = add_a;
        q_out   = {q_in[DATA_W-2:0], 1'b0};
      end
    end else begin
      acc_out  = {sum[DATA_W], sum[DATA_W:1]};
      q_out    = {sum[0], q_in[DATA_W-1:1]};
      q_m1_out = q_in[0];
    end
  end

endmodule

// File: rtl/hilo_muldiv.sv
// Sequential signed multiply/divide unit feeding the Hi and Lo registers.
// Control FSM, iteration counter and final sign correction live here; the
// per-cycle arithmetic is in muldiv_step. Only WIDTH = 32 is supported.
module hilo_muldiv
  import muldiv_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             op_q, op_d;
  logic [WIDTH:0]   acc_q, acc_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             q_m1_q, q_m1_d;
  logic [WIDTH:0]   m_q, m_d;
  logic             q_neg_q, q_neg_d;
  logic             r_neg_q, r_neg_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             div_zero_q, div_zero_d;

  logic [WIDTH:0]   step_acc;
  logic [WIDTH-1:0] step_q;
  logic             step_q_m1;
  logic [WIDTH-1:0] res_hi;
  logic [WIDTH-1:0] res_lo;

  muldiv_step u_step (
    .op       (op_q),
    .acc_in   (acc_q),
    .q_in     (q_q),
    .q_m1_in  (q_m1_q),
    .m_in     (m_q),
    .acc_out  (step_acc),
    .q_out    (step_q),
    .q_m1_out (step_q_m1)
  );

  // Final Hi/Lo values from the last iteration, with divide sign correction
  // (quotient truncates toward zero, remainder follows the dividend).
  always_comb begin
    res_hi = step_acc[WIDTH-1:0];
    res_lo = step_q;
    if (op_q == OP_DIV) begin
      res_lo = q_neg_q ? negate(step_q) : step_q;
      res_hi = r_neg_q ? negate(step_acc[WIDTH-1:0]) : step_acc[WIDTH-1:0];
    end
  end

  // Next-state logic: accept a request in IDLE, iterate in RUN and load
  // Hi/Lo on the last iteration edge so they are valid throughout FIN.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    op_d       = op_q;
    acc_d      = acc_q;
    q_d        = q_q;
    q_m1_d     = q_m1_q;
    m_d        = m_q;
    q_neg_d    = q_neg_q;
    r_neg_d    = r_neg_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    div_zero_d = div_zero_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          op_d       = op;
          count_d    = '0;
          div_zero_d = 1'b0;
          acc_d      = '0;
          q_m1_d     = 1'b0;
          q_neg_d    = a[WIDTH-1] ^ b[WIDTH-1];
          r_neg_d    = a[WIDTH-1];
          if (op == OP_DIV) begin
            q_d = magnitude(a);
            m_d = {1'b0, magnitude(b)};
            if (b == '0) begin
              state_d    = FIN;
              div_zero_d = 1'b1;
            end else begin
              state_d = RUN;
            end
          end else begin
            q_d     = a;
            m_d     = {b[WIDTH-1], b};
            state_d = RUN;
          end
        end
      end
      RUN: begin
        acc_d   = step_acc;
        q_d     = step_q;
        q_m1_d  = step_q_m1;
        count_d = count_q + CNT_W'(1);
        if (count_q == CNT_W'(ITER - 1)) begin
          state_d = FIN;
          hi_d    = res_hi;
          lo_d    = res_lo;
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      count_q    <= '0;
      op_q       <= OP_MULT;
      acc_q      <= '0;
      q_q        <= '0;
      q_m1_q     <= 1'b0;
      m_q        <= '0;
      q_neg_q    <= 1'b0;
      r_neg_q    <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      op_q       <= op_d;
      acc_q      <= acc_d;
      q_q        <= q_d;
      q_m1_q     <= q_m1_d;
      m_q        <= m_d;
      q_neg_q    <= q_neg_d;
      r_neg_q    <= r_neg_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign hi       = hi_q;
  assign lo       = lo_q;
  assign div_zero = div_zero_q;
  assign busy     = (state_q != IDLE);
  assign done     = (state_q == FIN);

endmodule

// File: tb/tb_hilo_muldiv.sv
// Self-checking bench for hilo_muldiv against a plain-arithmetic model.
module tb_hilo_muldiv;

  logic        clk;
  logic        reset;
  logic        start;
  logic        op;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;
  logic        div_zero;

  int vectors     = 0;
  int miscompares = 0;

  logic [31:0] exp_hi;
  logic [31:0] exp_lo;
  logic        exp_dz;

  hilo_muldiv #(.WIDTH(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .hi       (hi),
    .lo       (lo),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero)
  );

  // Free-running clock, 10 time units per cycle.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: MIPS MULT/DIV semantics using 64-bit signed arithmetic.
  task automatic model_op(input logic mop, input logic [31:0] ma, input logic [31:0] mb);
    longint sa, sb, prod, quo, rem;
    sa = longint'($signed(ma));
    sb = longint'($signed(mb));
    exp_dz = 1'b0;
    if (mop == 1'b0) begin
      prod   = sa * sb;
      exp_hi = prod[63:32];
      exp_lo = prod[31:0];
    end else if (mb == 32'd0) begin
      exp_dz = 1'b1;
    end else begin
      quo    = sa / sb;
      rem    = sa % sb;
      exp_lo = quo[31:0];
      exp_hi = rem[31:0];
    end
  endtask

  // Expected start-to-done latency in cycles (start cycle is cycle 0).
  function automatic int exp_latency(input logic mop, input logic [31:0] mb);
    return (mop == 1'b1 && mb == 32'd0) ? 1 : 33;
  endfunction

  // Issue one operation in the next cycle and wait (bounded) for done.
  task automatic run_op(input logic mop, input logic [31:0] ma, input logic [31:0] mb,
                        output int cyc, output logic idle_ok, output logic busy1);
    @(negedge clk);
    idle_ok = (busy === 1'b0) && (done === 1'b0);
    start = 1'b1;
    op    = mop;
    a     = ma;
    b     = mb;
    @(negedge clk);
    start = 1'b0;
    a     = $urandom;
    b     = $urandom;
    op    = ~mop;
    cyc   = 1;
    busy1 = busy;
    while (done !== 1'b1 && cyc < 60) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  function automatic logic [31:0] pick_operand(input int zero_pct);
    int r;
    r = $urandom_range(0, 99);
    if (r < zero_pct) return 32'd0;
    case ($urandom_range(0, 9))
      0: return 32'h8000_0000;
      1: return 32'h7FFF_FFFF;
      2: return 32'hFFFF_FFFF;
      3: return 32'd1;
      4: return $urandom_range(0, 20);
      5: return -$urandom_range(1, 20);
      default: return $urandom;
    endcase
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    op    = 1'b0;
    a     = '0;
    b     = '0;
    repeat (3) @(negedge clk);
    exp_hi = '0;
    exp_lo = '0;
    exp_dz = 1'b0;
    vectors++;
    if (hi !== 32'd0) begin miscompares++; $display("[TB] FAIL reset_hi got %h want 0", hi); end
    vectors++;
    if (lo !== 32'd0) begin miscompares++; $display("[TB] FAIL reset_lo got %h want 0", lo); end
    vectors++;
    if ({busy, done, div_zero} !== 3'b000)
      begin miscompares++; $display("[TB] FAIL reset_flags busy/done/dz got %b want 000", {busy, done, div_zero}); end
    reset = 1'b0;
  endtask

  task automatic test_mult_directed();
    logic [31:0] ta [3];
    logic [31:0] tb [3];
    int cyc;
    logic idle_ok, busy1;
    ta = '{32'd7, 32'h8000_0000, 32'h7FFF_FFFF};
    tb = '{32'hFFFF_FFFD, 32'h8000_0000, 32'h7FFF_FFFF};
    for (int i = 0; i < 3; i++) begin
      run_op(1'b0, ta[i], tb[i], cyc, idle_ok, busy1);
      model_op(1'b0, ta[i], tb[i]);
      vectors++;
      if (cyc !== 33) begin miscompares++; $display("[TB] FAIL mult_latency[%0d] got %0d want 33", i, cyc); end
      vectors++;
      if ({hi, lo} !== {exp_hi, exp_lo})
        begin miscompares++; $display("[TB] FAIL mult_result[%0d] got %h_%h want %h_%h", i, hi, lo, exp_hi, exp_lo); end
      vectors++;
      if (busy1 !== 1'b1) begin miscompares++; $display("[TB] FAIL mult_busy[%0d] got %b want 1", i, busy1); end
    end
  endtask

  task automatic test_div_directed();
    logic [31:0] ta [2];
    logic [31:0] tb [2];
    int cyc;
    logic idle_ok, busy1;
    ta = '{32'hFFFF_FFF9, 32'h8000_0000};
    tb = '{32'd2, 32'hFFFF_FFFF};
    for (int i = 0; i < 2; i++) begin
      run_op(1'b1, ta[i], tb[i], cyc, idle_ok, busy1);
      model_op(1'b1, ta[i], tb[i]);
      vectors++;
      if (cyc !== 33) begin miscompares++; $display("[TB] FAIL div_latency[%0d] got %0d want 33", i, cyc); end
      vectors++;
      if ({hi, lo, div_zero} !== {exp_hi, exp_lo, exp_dz})
        begin miscompares++; $display("[TB] FAIL div_result[%0d] got %h_%h dz=%b want %h_%h dz=%b",
                                      i, hi, lo, div_zero, exp_hi, exp_lo, exp_dz); end
    end
  endtask

  task automatic test_div_zero();
    int cyc;
    logic idle_ok, busy1;
    logic [31:0] ma, mb;
    // Quotient 0x5678, remainder 0x1234 preloads Hi/Lo.
    run_op(1'b1, 32'h5678_1234, 32'h0001_0000, cyc, idle_ok, busy1);
    model_op(1'b1, 32'h5678_1234, 32'h0001_0000);
    vectors++;
    if ({hi, lo} !== {exp_hi, exp_lo})
      begin miscompares++; $display("[TB] FAIL dz_preload got %h_%h want %h_%h", hi, lo, exp_hi, exp_lo); end
    run_op(1'b1, 32'd5, 32'd0, cyc, idle_ok, busy1);
    model_op(1'b1, 32'd5, 32'd0);
    vectors++;
    if (cyc !== 1) begin miscompares++; $display("[TB] FAIL dz_latency got %0d want 1", cyc); end
    vectors++;
    if ({hi, lo, div_zero} !== {exp_hi, exp_lo, exp_dz})
      begin miscompares++; $display("[TB] FAIL dz_result got %h_%h dz=%b want %h_%h dz=%b",
                                    hi, lo, div_zero, exp_hi, exp_lo, exp_dz); end
    @(negedge clk);
    vectors++;
    if ({div_zero, done, busy} !== 3'b100)
      begin miscompares++; $display("[TB] FAIL dz_hold dz/done/busy got %b want 100", {div_zero, done, busy}); end
    ma = $urandom;
    mb = $urandom;
    run_op(1'b0, ma, mb, cyc, idle_ok, busy1);
    model_op(1'b0, ma, mb);
    vectors++;
    if ({hi, lo, div_zero} !== {exp_hi, exp_lo, exp_dz})
      begin miscompares++; $display("[TB] FAIL dz_clear got %h_%h dz=%b want %h_%h dz=%b",
                                    hi, lo, div_zero, exp_hi, exp_lo, exp_dz); end
  endtask

  task automatic test_busy_start();
    logic [31:0] ma, mb;
    int cyc;
    ma = $urandom;
    mb = $urandom | 32'd1;
    @(negedge clk);
    start = 1'b1;
    op    = 1'b1;
    a     = ma;
    b     = mb;
    @(negedge clk);
    start = 1'b0;
    cyc   = 1;
    while (done !== 1'b1 && cyc < 60) begin
      if (cyc == 10) begin
        start = 1'b1;
        op    = 1'b0;
        a     = $urandom;
        b     = 32'd0;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    model_op(1'b1, ma, mb);
    vectors++;
    if (cyc !== 33) begin miscompares++; $display("[TB] FAIL busy_start_latency got %0d want 33", cyc); end
    vectors++;
    if ({hi, lo, div_zero} !== {exp_hi, exp_lo, exp_dz})
      begin miscompares++; $display("[TB] FAIL busy_start_result got %h_%h dz=%b want %h_%h dz=%b",
                                    hi, lo, div_zero, exp_hi, exp_lo, exp_dz); end
  endtask

  task automatic test_reset_mid();
    int cyc, done_seen;
    logic idle_ok, busy1;
    logic [31:0] ma, mb;
    run_op(1'b0, 32'd7, 32'hFFFF_FFFD, cyc, idle_ok, busy1);
    model_op(1'b0, 32'd7, 32'hFFFF_FFFD);
    @(negedge clk);
    start = 1'b1;
    op    = 1'b0;
    a     = $urandom;
    b     = $urandom;
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_hi = '0;
    exp_lo = '0;
    exp_dz = 1'b0;
    vectors++;
    if ({hi, lo, busy, done, div_zero} !== 67'd0)
      begin miscompares++; $display("[TB] FAIL midreset_outputs got %h_%h busy=%b done=%b dz=%b want all 0",
                                    hi, lo, busy, done, div_zero); end
    done_seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) done_seen++;
    end
    vectors++;
    if (done_seen !== 0) begin miscompares++; $display("[TB] FAIL midreset_no_done got %0d want 0", done_seen); end
    ma = $urandom;
    mb = $urandom;
    run_op(1'b0, ma, mb, cyc, idle_ok, busy1);
    model_op(1'b0, ma, mb);
    vectors++;
    if (cyc !== 33 || {hi, lo} !== {exp_hi, exp_lo})
      begin miscompares++; $display("[TB] FAIL midreset_recover got %h_%h cyc=%0d want %h_%h cyc=33",
                                    hi, lo, cyc, exp_hi, exp_lo); end
  endtask

  task automatic test_back_to_back();
    int cyc;
    logic idle_ok, busy1;
    logic [31:0] ma, mb;
    logic mop;
    for (int i = 0; i < 40; i++) begin
      mop = 1'($urandom_range(0, 1));
      ma  = pick_operand(5);
      mb  = pick_operand(12);
      run_op(mop, ma, mb, cyc, idle_ok, busy1);
      model_op(mop, ma, mb);
      vectors++;
      if (cyc !== exp_latency(mop, mb))
        begin miscompares++; $display("[TB] FAIL b2b_latency[%0d] got %0d want %0d", i, cyc, exp_latency(mop, mb)); end
      vectors++;
      if ({hi, lo, div_zero} !== {exp_hi, exp_lo, exp_dz})
        begin miscompares++; $display("[TB] FAIL b2b_result[%0d] op=%b a=%h b=%h got %h_%h dz=%b want %h_%h dz=%b",
                                      i, mop, ma, mb, hi, lo, div_zero, exp_hi, exp_lo, exp_dz); end
      vectors++;
      if (idle_ok !== 1'b1 || busy1 !== 1'b1)
        begin miscompares++; $display("[TB] FAIL b2b_handshake[%0d] idle=%b busy=%b want 1 1", i, idle_ok, busy1); end
    end
  endtask

  initial begin
    test_reset();
    test_mult_directed();
    test_div_directed();
    test_div_zero();
    test_busy_start();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
